seg_scan_mux: RTL and testbench
===============================

# seg_scan_mux

Time-multiplexing scan driver for the four-digit seven-segment display. It holds a 16-bit hex value and cycles through the four digits in turn. For each digit it presents the selected nibble plus an active-low one-cold digit select to the downstream hex-to-segment decoder. Digit 1 carries the decimal point. The block adds anti-ghosting blank time, tear-free frame-aligned updates and optional leading-zero suppression.

## Interface

Parameters:
- ON_CYCLES, 12000: clock cycles a digit is lit per slot; must be ≥1.
- BLANK_CYCLES, 500: dead cycles with all digits off before each lit period; must be ≥1.

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- rst_n, input, 1: asynchronous active-low reset. The block has one clock; reset is asynchronous and active-low.
- data_in, input, 16: value to display; nibble k drives digit k.
- load, input, 1: single-cycle strobe; captures data_in and lz_en.
- lz_en, input, 1: leading-zero suppression enable, captured with load.
- nib_out, output, 4: nibble for the current digit, to decoder in_4.
- sel_out, output, 4: digit enables, active-low, one-cold. Digit k lit means bit k = 0. Digit 1 = 4'b1101 (decimal-point digit).
- frame_done, output, 1: one-cycle pulse at each frame wrap.

## Operation

- Registers:
  - shadow[15:0] and shadow_lz: written by load.
  - active[15:0] and active_lz: the values currently displayed.
  - pending flag.
  - idx[1:0]: current digit.
  - cnt: slot counter, sized for max(ON_CYCLES, BLANK_CYCLES)-1.
  - state: BLANK or SHOW.
- Reset values: state=BLANK, idx=0, cnt=0, shadow=active=0, shadow_lz=active_lz=0, pending=0, nib_out=0, sel_out=4'b1111, frame_done=0.
- load=1: shadow<=data_in, shadow_lz<=lz_en, pending<=1. A later load before the frame wrap overwrites it; the newest value wins.
- BLANK:
  - sel_out=4'b1111; nib_out=active[4*idx+:4].
  - After BLANK_CYCLES cycles: cnt<=0, go to SHOW.
- SHOW:
  - sel_out=~(4'b0001<<idx), unless the digit is suppressed, in which case sel_out=4'b1111.
  - After ON_CYCLES cycles: cnt<=0, idx<=idx+1 (3 wraps to 0), go to BLANK.
- Frame wrap (SHOW→BLANK with idx=3):
  - frame_done<=1 for one cycle.
  - If pending: active<=shadow, active_lz<=shadow_lz, pending<=0.
  - nib_out for digit 0 comes from the new active value in that same edge.
- load in the same cycle as a frame wrap: data_in is transferred directly to active in that wrap and pending stays 0. The new value is never lost or delayed a frame.
- Leading-zero suppression: when active_lz=1, digit k>0 is suppressed if all of active[15:4k] is zero. Digit 0 is never suppressed, so an all-zero value shows "0".
- Display contents change only at frame boundaries. No torn frames.
- Reset mid-scan: all outputs return to reset values immediately (asynchronous). Scanning restarts at digit 0 in BLANK.

## Timing

- All outputs registered; no combinational input-to-output path.
- Slot = BLANK_CYCLES+ON_CYCLES cycles. Frame = 4×slot.
- After rst_n release, sel_out first goes low on the BLANK_CYCLES-th rising edge. It then stays low for ON_CYCLES cycles.
- nib_out changes only on entry to BLANK. It is therefore stable for at least BLANK_CYCLES cycles before any sel_out bit asserts, and throughout the lit period.
- Latency from load to visible: at most 1 frame plus BLANK_CYCLES cycles.
- frame_done is high during the first BLANK cycle of digit 0.

## Structure

- Shared display package holds:
  - the state enum (BLANK, SHOW);
  - the digit-count constant (4);
  - the active-low select constants SEL_NONE=4'b1111 and SEL_DP=4'b1101, shared with the decoder.
- One natural sub-module: seg_scan_timer, the cnt/state sequencer that emits slot_end and blank_end strobes.
- Leading-zero logic and the data registers stay inline.

## Test plan

Use ON_CYCLES=4, BLANK_CYCLES=2 throughout.

1. **Reset and basic scan.** Assert rst_n low, release, then load 16'h1234 with lz_en=0.
   - Before the load takes effect: digits show 0.
   - After the next frame wrap, per slot: nib_out=4,3,2,1 with sel_out 1110, 1101, 1011, 0111, each low for exactly 4 cycles after 2 cycles of 1111.
   - frame_done pulses every 24 cycles.
2. **Tear-free update.** Load 16'hABCD during digit 1 of a frame.
   - The rest of that frame shows the old value.
   - The next frame shows D, C, B, A.
3. **Back-to-back loads.** Load 16'h1111, then 16'h2222 in the same frame → only 2222 is displayed next frame.
4. **Load coinciding with the wrap edge.** Load 16'h5A5A on the wrap edge → digit 0 of the immediately following frame shows nibble A.
5. **Leading-zero suppression.** With lz_en=1:
   - Load 16'h0030 → digits 2 and 3 keep sel_out=1111; digit 1 shows 3; digit 0 shows 0.
   - Load 16'h0000 → only digit 0 lit, showing 0.
6. **Asynchronous reset mid-SHOW.** Drop rst_n mid-SHOW of digit 2 → sel_out=1111, nib_out=0 and frame_done=0 immediately, without waiting for a clock edge; after release, scanning resumes at digit 0 and the prior value is cleared.

Source files
------------

// File: rtl/seg_scan_mux_pkg.sv
// Shared display definitions: scan states, digit count, active-low select codes
// and the per-digit select/suppression helpers.
package seg_scan_mux_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    localparam int unsigned NUM_DIGITS = 4;

    localparam logic [3:0] SEL_NONE = 4'b1111;
    localparam logic [3:0] SEL_DP   = 4'b1101;

    function automatic logic [3:0] digit_sel(input logic [1:0] idx);
        logic [3:0] sel;
        case (idx)
            2'd0:    sel = 4'b1110;
            2'd1:    sel = SEL_DP;
            2'd2:    sel = 4'b1011;
            default: sel = 4'b0111;
        endcase
        return sel;
    endfunction

    // Digit k>0 is blank when every nibble from k upward is zero.
    function automatic logic lz_suppress(input logic [15:0] value,
                                         input logic        lz,
                                         input logic [1:0]  idx);
        logic [15:0] upper;
        upper = value >> {idx, 2'b00};
        return lz && (idx != 2'd0) && (upper == '0);
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot sequencer: counts BLANK then SHOW cycles for each digit slot and
// strobes the last cycle of each phase.
module seg_scan_timer
    import seg_scan_mux_pkg::*;
#(
    parameter int unsigned ON_CYCLES    = 12000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_blank_end,
    output logic o_slot_end
);

    localparam int unsigned MAX_CYC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    scan_state_t      r_state;
    scan_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        o_blank_end = 1'b0;
        o_slot_end  = 1'b0;
        case (r_state)
            ST_BLANK: begin
                if (r_cnt == BLANK_LAST) begin
                    o_blank_end = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (r_cnt == ON_LAST) begin
                    o_slot_end  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_BLANK;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_BLANK;
            end
        endcase
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Four-digit seven-segment scan driver with blank-time anti-ghosting,
// frame-aligned value updates and optional leading-zero suppression.
module seg_scan_mux
    import seg_scan_mux_pkg::*;
#(
    parameter int unsigned ON_CYCLES    = 12000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data_in,
    input  logic        load,
    input  logic        lz_en,
    output logic [3:0]  nib_out,
    output logic [3:0]  sel_out,
    output logic        frame_done
);

    localparam logic [1:0] LAST_IDX = 2'(NUM_DIGITS - 1);

    logic        w_blank_end;
    logic        w_slot_end;
    logic        w_wrap;
    logic [1:0]  w_idx_nxt;
    logic [15:0] w_active_nxt;
    logic        w_active_lz_nxt;

    logic [15:0] r_shadow;
    logic        r_shadow_lz;
    logic [15:0] r_active;
    logic        r_active_lz;
    logic        r_pending;
    logic [1:0]  r_idx;

    seg_scan_timer #(
        .ON_CYCLES    (ON_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .o_blank_end (w_blank_end),
        .o_slot_end  (w_slot_end)
    );

    assign w_wrap    = w_slot_end && (r_idx == LAST_IDX);
    assign w_idx_nxt = w_slot_end ? (r_idx + 2'd1) : r_idx;

    // A load on the wrap edge bypasses the shadow so it lands in this frame.
    always_comb begin
        w_active_nxt    = r_active;
        w_active_lz_nxt = r_active_lz;
        if (w_wrap) begin
            if (load) begin
                w_active_nxt    = data_in;
                w_active_lz_nxt = lz_en;
            end else if (r_pending) begin
                w_active_nxt    = r_shadow;
                w_active_lz_nxt = r_shadow_lz;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow    <= '0;
            r_shadow_lz <= 1'b0;
            r_active    <= '0;
            r_active_lz <= 1'b0;
            r_pending   <= 1'b0;
            r_idx       <= '0;
            nib_out     <= '0;
            sel_out     <= SEL_NONE;
            frame_done  <= 1'b0;
        end else begin
            if (load) begin
                r_shadow    <= data_in;
                r_shadow_lz <= lz_en;
            end
            if (w_wrap) begin
                r_pending <= 1'b0;
            end else if (load) begin
                r_pending <= 1'b1;
            end
            r_active    <= w_active_nxt;
            r_active_lz <= w_active_lz_nxt;
            r_idx       <= w_idx_nxt;
            frame_done  <= w_wrap;
            if (w_slot_end) begin
                sel_out <= SEL_NONE;
                nib_out <= w_active_nxt[{w_idx_nxt, 2'b00} +: 4];
            end else if (w_blank_end) begin
                sel_out <= lz_suppress(r_active, r_active_lz, r_idx) ? SEL_NONE
                                                                     : digit_sel(r_idx);
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: stimulus queues the expected nibble/select
// per digit slot; the monitor rebuilds each slot from the outputs and compares.
module tb_seg_scan_mux;

    localparam int unsigned ON    = 4;
    localparam int unsigned BL    = 2;
    localparam int unsigned SLOT  = ON + BL;
    localparam int unsigned FRAME = 4 * SLOT;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic [15:0] data_in = '0;
    logic        load    = 1'b0;
    logic        lz_en   = 1'b0;
    logic [3:0]  nib_out;
    logic [3:0]  sel_out;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    seg_scan_mux #(
        .ON_CYCLES    (ON),
        .BLANK_CYCLES (BL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .load       (load),
        .lz_en      (lz_en),
        .nib_out    (nib_out),
        .sel_out    (sel_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Reference: find the most significant nonzero digit; digits above it go dark.
    function automatic logic [7:0] exp_entry(input logic [15:0] v, input logic lz, input int k);
        int hi;
        logic [3:0] sel;
        logic [3:0] nib;
        hi = 0;
        for (int i = 0; i < 4; i++)
            if (v[4*i +: 4] != 4'h0) hi = i;
        nib = v[4*k +: 4];
        sel = 4'b1111;
        if (!lz || k <= hi) sel[k] = 1'b0;
        return {nib, sel};
    endfunction

    task automatic push_frame(input logic [15:0] v, input logic lz);
        for (int k = 0; k < 4; k++) exp_q.push_back(exp_entry(v, lz, k));
    endtask

    task automatic push_exp(input logic [3:0] nib, input logic [3:0] sel);
        exp_q.push_back({nib, sel});
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 60);
        checks++;
        if (!frame_done) begin
            errors++;
            $display("FAIL frame_wait: no frame_done after %0d cycles, required within 60", n);
        end
    endtask

    task automatic load_at(input int delay, input logic [15:0] d, input logic lz);
        repeat (delay) @(negedge clk);
        #1;
        data_in = d;
        lz_en   = lz;
        load    = 1'b1;
        @(negedge clk);
        #1;
        load    = 1'b0;
        data_in = '0;
        lz_en   = 1'b0;
    endtask

    initial begin : monitor
        int p;
        int q;
        logic [3:0] a_nib;
        logic [3:0] a_sel;
        logic steady;
        logic [7:0] e;
        p = 0;
        a_nib = '0;
        a_sel = '1;
        steady = 1'b1;
        #1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check4("reset_sel", sel_out, 4'b1111);
                check4("reset_nib", nib_out, 4'h0);
                check1("reset_frame_done", frame_done, 1'b0);
                p = 0;
                a_nib = nib_out;
                steady = 1'b1;
            end else begin
                p = (p + 1) % FRAME;
                q = p % SLOT;
                check1($sformatf("frame_done_p%0d", p), frame_done, (p == 0));
                if (q == 0) begin
                    a_nib = nib_out;
                    steady = 1'b1;
                end else if (nib_out !== a_nib) begin
                    steady = 1'b0;
                end
                if (q < BL) begin
                    if (sel_out !== 4'b1111) steady = 1'b0;
                end else if (q == BL) begin
                    a_sel = sel_out;
                end else if (sel_out !== a_sel) begin
                    steady = 1'b0;
                end
                if (q == SLOT - 1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL slot_unexpected: got slot nib %h sel %b, required none", a_nib, a_sel);
                    end else begin
                        e = exp_q.pop_front();
                        check4($sformatf("slot%0d_nib", p / SLOT), a_nib, e[7:4]);
                        check4($sformatf("slot%0d_sel", p / SLOT), a_sel, e[3:0]);
                        check1($sformatf("slot%0d_timing", p / SLOT), steady, 1'b1);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        repeat (3) @(negedge clk);
        push_frame(16'h0000, 1'b0);
        #1 rst_n = 1'b1;
        load_at(3, 16'h1234, 1'b0);

        wait_frame();
        push_exp(4'h4, 4'b1110);
        push_exp(4'h3, 4'b1101);
        push_exp(4'h2, 4'b1011);
        push_exp(4'h1, 4'b0111);
        load_at(8, 16'hABCD, 1'b0);

        wait_frame();
        push_frame(16'hABCD, 1'b0);
        load_at(3, 16'h1111, 1'b0);
        load_at(6, 16'h2222, 1'b0);

        wait_frame();
        push_frame(16'h2222, 1'b0);
        load_at(23, 16'h5A5A, 1'b0);
        push_frame(16'h5A5A, 1'b0);
        load_at(3, 16'h0030, 1'b1);

        wait_frame();
        push_exp(4'h0, 4'b1110);
        push_exp(4'h3, 4'b1101);
        push_exp(4'h0, 4'b1111);
        push_exp(4'h0, 4'b1111);
        load_at(3, 16'h0000, 1'b1);

        wait_frame();
        push_exp(4'h0, 4'b1110);
        push_exp(4'h0, 4'b1111);
        push_exp(4'h0, 4'b1111);
        push_exp(4'h0, 4'b1111);
        load_at(3, 16'h0F0F, 1'b0);

        wait_frame();
        push_exp(4'hF, 4'b1110);
        push_exp(4'h0, 4'b1101);
        repeat (15) @(negedge clk);
        check4("pre_reset_sel", sel_out, 4'b1011);
        check4("pre_reset_nib", nib_out, 4'hF);
        #2 rst_n = 1'b0;
        #1;
        check4("async_reset_sel", sel_out, 4'b1111);
        check4("async_reset_nib", nib_out, 4'h0);
        check1("async_reset_frame_done", frame_done, 1'b0);
        repeat (2) @(negedge clk);
        push_frame(16'h0000, 1'b0);
        #1 rst_n = 1'b1;

        wait_frame();
        push_frame(16'h0000, 1'b0);
        wait_frame();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d unconsumed slots, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
